pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk and reset.
REQ-002 Parameters SHALL be: CNT_W, 16, width of performance counters; MEM_TIMEOUT, 64, max wait cycles for a data-memory ack.
REQ-003 Ports SHALL be:
- clk  in  1  pipeline clock
- reset  in  1  async active-low reset
- ifid_rs1  in  5  rs1 field of the IF/ID instruction
- ifid_rs2  in  5  rs2 field of the IF/ID instruction
- ifid_uses_rs2  in  1  IF/ID instruction reads rs2
- idex_memread  in  1  ID/EX MemRead
- idex_rd  in  5  ID/EX destination
- ex_redirect  in  1  taken branch, jal or jalr resolved in EX
- exmem_memread  in  1  EX/MEM MemRead
- exmem_memwrite  in  1  EX/MEM MemWrite
- mem_ack  in  1  data memory completes the access
- mem_req  out  1  data memory access request
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage-register load enables
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (all control bits 0)
- stall_cnt  out  CNT_W  cycles with pc_en=0
- flush_cnt  out  CNT_W  redirect events
- err  out  1  sticky memory timeout

Function
REQ-004 The FSM SHALL have three states: RUN, MEM_WAIT and ERROR.
REQ-005 mem_access SHALL be exmem_memread OR exmem_memwrite.
REQ-006 In RUN with mem_access=1, mem_req SHALL be 1 in the same cycle.
REQ-007 In RUN with mem_access=1 and mem_ack=1 (zero-wait), the pipeline SHALL advance normally and the state SHALL stay RUN.
REQ-008 In RUN with mem_access=1 and mem_ack=0, the block SHALL freeze the pipeline: all enables 0 except memwb_en=1 with memwb_flush=1. The next state SHALL be MEM_WAIT.
REQ-009 In MEM_WAIT, mem_req SHALL stay 1 and the freeze of REQ-008 SHALL apply.
REQ-010 In MEM_WAIT with mem_ack=1, all enables SHALL be 1, no flush SHALL be asserted, and the next state SHALL be RUN.
REQ-011 A wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle without ack. When it reaches MEM_TIMEOUT, the next state SHALL be ERROR.
REQ-012 In ERROR, all enables, flushes and mem_req SHALL be 0 and err SHALL be 1. ERROR SHALL be left only by reset.
REQ-013 While a memory stall is active (REQ-008 or REQ-009), ex_redirect and load-use SHALL be ignored. They are re-evaluated after release because the stage contents are frozen.
REQ-014 In RUN with no memory stall and ex_redirect=1: pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, idex_flush=1; flush_cnt increments.
REQ-015 Load-use SHALL be true when all of the following hold:
- idex_memread=1
- idex_rd is not 0
- idex_rd equals ifid_rs1, or idex_rd equals ifid_rs2 with ifid_uses_rs2=1
REQ-016 In RUN with no memory stall, load-use and no redirect: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1. This stalls exactly one cycle.
REQ-017 When redirect and load-use occur together, redirect SHALL win, because the load-use consumer is on the wrong path.
REQ-018 With no stall, redirect or error: all enables SHALL be 1 and all flushes 0.
REQ-019 stall_cnt SHALL increment in each cycle with pc_en=0 outside ERROR. stall_cnt and flush_cnt SHALL saturate at all-ones.
REQ-020 Enables, flushes and mem_req SHALL be combinational from state and inputs. State, counters and err SHALL be registered.

Reset
REQ-021 While reset=0: state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, err=0, and all enables, flushes and mem_req are forced to 0.
REQ-022 Reset asserted mid-MEM_WAIT or in ERROR SHALL abort immediately. After release, the block SHALL begin in RUN.

Structure
REQ-023 The shared pipeline package SHALL hold the FSM state enum and a packed stage-control struct containing the en/flush bits.
REQ-024 Load-use compare logic SHALL be a combinational sub-module, load_use_detect.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Load-use: idex_memread=1, idex_rd=5, ifid_rs1=5 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1.
- idex_rd=0 with matching rs1=0 -> no stall.
- ex_redirect=1 together with load-use -> ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt=1; stall_cnt unchanged.
- exmem_memread=1, mem_ack after 3 cycles -> mem_req high 4 cycles, 3 freeze cycles with memwb_flush=1, stall_cnt=3; an ex_redirect held during the wait flushes only on the ack cycle.
- mem_ack never asserted, MEM_TIMEOUT=4 -> ERROR after 4 wait cycles, err=1, all enables 0; reset then returns to RUN with err=0.
- Counter saturation with CNT_W=2 -> stall_cnt holds at 3.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline types: hazard FSM states and the stage-register control bundle.
// Also holds the per-cycle control patterns used by the hazard controller.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
        logic memwb_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_NONE = '0;

    // Memory stall: hold everything upstream of MEM, push a bubble into WB.
    localparam stage_ctrl_t CTRL_FREEZE = '{
        pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
        idex_en: 1'b0, idex_flush: 1'b0, exmem_en: 1'b0,
        memwb_en: 1'b1, memwb_flush: 1'b1
    };

    // Control-hazard and data-hazard resolution for an unfrozen pipeline.
    // Redirect wins: a load-use consumer behind a redirect is wrong-path.
    function automatic stage_ctrl_t hazard_ctrl(input logic redirect,
                                                input logic load_use);
        stage_ctrl_t c;
        c = '{
            pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
            idex_en: 1'b1, idex_flush: 1'b0, exmem_en: 1'b1,
            memwb_en: 1'b1, memwb_flush: 1'b0
        };
        if (redirect) begin
            c.ifid_flush = 1'b1;
            c.idex_flush = 1'b1;
        end else if (load_use) begin
            c.pc_en      = 1'b0;
            c.ifid_en    = 1'b0;
            c.idex_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare between the ID/EX load and the IF/ID consumer.
// Ports: idex_memread/idex_rd, ifid_rs1/ifid_rs2/ifid_uses_rs2 in; load_use out.
module load_use_detect (
    input  logic       idex_memread,
    input  logic [4:0] idex_rd,
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    input  logic       ifid_uses_rs2,
    output logic       load_use
);

    logic hit_rs1;
    logic hit_rs2;

    assign hit_rs1  = (idex_rd == ifid_rs1);
    assign hit_rs2  = ifid_uses_rs2 && (idex_rd == ifid_rs2);
    // x0 is never a real dependency.
    assign load_use = idex_memread && (idex_rd != 5'd0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-ack stalls with timeout, redirect flush, load-use stall.
// Ports: hazard inputs in; stage enables/flushes, mem_req, stall/flush counters, err out.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_uses_rs2,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic             ex_redirect,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_t   state;
    hz_state_t   state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    stage_ctrl_t ctrl_raw;
    stage_ctrl_t ctrl;
    logic        req_raw;
    logic        mem_access;
    logic        load_use;
    logic        redirect_evt;
    logic        stall_evt;

    load_use_detect u_lud (
        .idex_memread  (idex_memread),
        .idex_rd       (idex_rd),
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .ifid_uses_rs2 (ifid_uses_rs2),
        .load_use      (load_use)
    );

    assign mem_access = exmem_memread | exmem_memwrite;

    // The ack cycle releases the freeze, so hazards are judged normally
    // there; while frozen they are ignored because nothing moves.
    always_comb begin
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        ctrl_raw     = CTRL_NONE;
        req_raw      = 1'b0;
        redirect_evt = 1'b0;
        unique case (state)
            ST_RUN: begin
                req_raw = mem_access;
                if (mem_access && !mem_ack) begin
                    ctrl_raw  = CTRL_FREEZE;
                    state_nxt = ST_MEM_WAIT;
                    wait_nxt  = '0;
                end else begin
                    ctrl_raw     = hazard_ctrl(ex_redirect, load_use);
                    redirect_evt = ex_redirect;
                end
            end
            ST_MEM_WAIT: begin
                req_raw = 1'b1;
                if (mem_ack) begin
                    ctrl_raw     = hazard_ctrl(ex_redirect, load_use);
                    redirect_evt = ex_redirect;
                    state_nxt    = ST_RUN;
                end else begin
                    ctrl_raw = CTRL_FREEZE;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = ST_ERROR;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end
            end
            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    assign stall_evt = (state != ST_ERROR) && !ctrl_raw.pc_en;

    // Outputs are held low for as long as reset is asserted.
    assign ctrl    = reset ? ctrl_raw : CTRL_NONE;
    assign mem_req = reset & req_raw;

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.ifid_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_en     = ctrl.idex_en;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_en    = ctrl.exmem_en;
    assign memwb_en    = ctrl.memwb_en;
    assign memwb_flush = ctrl.memwb_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            err       <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            err      <= err | (state_nxt == ST_ERROR);
            if (stall_evt && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect_evt && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic.
// Two instances share stimulus: 16-bit counters and 2-bit counters, both MEM_TIMEOUT=4.
module tb_pipe_hazard_ctrl;

    localparam int TMO = 4;

    logic       clk;
    logic       reset;
    logic [4:0] ifid_rs1;
    logic [4:0] ifid_rs2;
    logic       ifid_uses_rs2;
    logic       idex_memread;
    logic [4:0] idex_rd;
    logic       ex_redirect;
    logic       exmem_memread;
    logic       exmem_memwrite;
    logic       mem_ack;

    logic        d_req, d_pc, d_ifid, d_idex, d_exmem, d_memwb;
    logic        d_ifid_f, d_idex_f, d_memwb_f, d_err;
    logic [15:0] d_stall, d_flush;
    logic        s_req, s_pc, s_ifid, s_idex, s_exmem, s_memwb;
    logic        s_ifid_f, s_idex_f, s_memwb_f, s_err;
    logic [1:0]  s_stall, s_flush;

    logic [8:0] d_vec;
    logic [8:0] s_vec;
    logic [8:0] last_obs;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    bit m_dead;
    bit m_waiting;
    int m_waited;
    int m_stalls;
    int m_flushes;
    int m_stalls_s;
    int m_flushes_s;

    pipe_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(TMO)) u_dut (
        .clk(clk), .reset(reset),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
        .idex_memread(idex_memread), .idex_rd(idex_rd), .ex_redirect(ex_redirect),
        .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
        .mem_ack(mem_ack), .mem_req(d_req),
        .pc_en(d_pc), .ifid_en(d_ifid), .idex_en(d_idex),
        .exmem_en(d_exmem), .memwb_en(d_memwb),
        .ifid_flush(d_ifid_f), .idex_flush(d_idex_f), .memwb_flush(d_memwb_f),
        .stall_cnt(d_stall), .flush_cnt(d_flush), .err(d_err)
    );

    pipe_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(TMO)) u_sat (
        .clk(clk), .reset(reset),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
        .idex_memread(idex_memread), .idex_rd(idex_rd), .ex_redirect(ex_redirect),
        .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
        .mem_ack(mem_ack), .mem_req(s_req),
        .pc_en(s_pc), .ifid_en(s_ifid), .idex_en(s_idex),
        .exmem_en(s_exmem), .memwb_en(s_memwb),
        .ifid_flush(s_ifid_f), .idex_flush(s_idex_f), .memwb_flush(s_memwb_f),
        .stall_cnt(s_stall), .flush_cnt(s_flush), .err(s_err)
    );

    // {pc, ifid, ifid_flush, idex, idex_flush, exmem, memwb, memwb_flush, mem_req}
    assign d_vec = {d_pc, d_ifid, d_ifid_f, d_idex, d_idex_f,
                    d_exmem, d_memwb, d_memwb_f, d_req};
    assign s_vec = {s_pc, s_ifid, s_ifid_f, s_idex, s_idex_f,
                    s_exmem, s_memwb, s_memwb_f, s_req};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ifid_rs1       = 5'd0;
        ifid_rs2       = 5'd0;
        ifid_uses_rs2  = 1'b0;
        idex_memread   = 1'b0;
        idex_rd        = 5'd0;
        ex_redirect    = 1'b0;
        exmem_memread  = 1'b0;
        exmem_memwrite = 1'b0;
        mem_ack        = 1'b0;
    endtask

    // One clock cycle: inputs already driven at the falling edge.
    task automatic step(input string tag);
        logic [8:0] e;
        bit acc, lu, frz, stall, redir, mr;
        #1;
        acc   = exmem_memread | exmem_memwrite;
        lu    = idex_memread && (idex_rd != 0) &&
                ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
        frz   = 1'b0;
        stall = 1'b0;
        redir = 1'b0;
        mr    = m_waiting || acc;
        if (!reset) begin
            m_dead = 0; m_waiting = 0; m_waited = 0;
            m_stalls = 0; m_flushes = 0; m_stalls_s = 0; m_flushes_s = 0;
            e = '0;
        end else if (m_dead) begin
            e = '0;
        end else if (mr && !mem_ack) begin
            frz   = 1'b1;
            stall = 1'b1;
            e     = 9'b0_0_0_0_0_0_1_1_1;
        end else if (ex_redirect) begin
            redir = 1'b1;
            e     = {8'b1_1_1_1_1_1_1_0, mr};
        end else if (lu) begin
            stall = 1'b1;
            e     = {8'b0_0_0_1_1_1_1_0, mr};
        end else begin
            e     = {8'b1_1_0_1_0_1_1_0, mr};
        end
        last_obs = d_vec;
        check({tag, ":ctrl"}, 32'(d_vec), 32'(e));
        check({tag, ":ctrl_s"}, 32'(s_vec), 32'(e));
        check({tag, ":stall_cnt"}, 32'(d_stall), 32'(m_stalls));
        check({tag, ":flush_cnt"}, 32'(d_flush), 32'(m_flushes));
        check({tag, ":stall_cnt_s"}, 32'(s_stall), 32'(m_stalls_s));
        check({tag, ":flush_cnt_s"}, 32'(s_flush), 32'(m_flushes_s));
        check({tag, ":err"}, 32'(d_err), 32'(m_dead));
        check({tag, ":err_s"}, 32'(s_err), 32'(m_dead));
        @(posedge clk);
        if (reset && !m_dead) begin
            if (frz) begin
                if (m_waiting) begin
                    m_waited++;
                    if (m_waited == TMO) begin
                        m_dead    = 1;
                        m_waiting = 0;
                    end
                end else begin
                    m_waiting = 1;
                    m_waited  = 0;
                end
            end else begin
                m_waiting = 0;
            end
            if (stall) begin
                m_stalls   = (m_stalls + 1 > 65535) ? 65535 : m_stalls + 1;
                m_stalls_s = (m_stalls_s + 1 > 3) ? 3 : m_stalls_s + 1;
            end
            if (redir) begin
                m_flushes   = (m_flushes + 1 > 65535) ? 65535 : m_flushes + 1;
                m_flushes_s = (m_flushes_s + 1 > 3) ? 3 : m_flushes_s + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step("rst");
        reset = 1'b1;
        clear_inputs();
    endtask

    int n_req;
    int n_wbf;
    int n_iff;

    initial begin
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);

        // Outputs forced low under reset even with active inputs.
        ex_redirect   = 1'b1;
        exmem_memread = 1'b1;
        idex_memread  = 1'b1;
        step("reset_hold");
        check("reset_ctrl", 32'(last_obs), 32'd0);
        reset = 1'b1;
        clear_inputs();
        step("idle");

        // Load-use stalls one cycle.
        do_reset();
        idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5;
        step("lu");
        check("lu_pc_en", 32'(last_obs[8]), 32'd0);
        idex_memread = 1'b0;
        step("lu_after");
        check("lu_stall_cnt", 32'(d_stall), 32'd1);

        // x0 never hazards.
        do_reset();
        idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0;
        step("x0");
        step("x0_after");
        check("x0_stall_cnt", 32'(d_stall), 32'd0);

        // rs2 match only counts when rs2 is read.
        do_reset();
        idex_memread = 1'b1; idex_rd = 5'd9; ifid_rs2 = 5'd9; ifid_rs1 = 5'd1;
        step("rs2_unused");
        ifid_uses_rs2 = 1'b1;
        step("rs2_used");

        // Redirect beats load-use.
        do_reset();
        idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5; ex_redirect = 1'b1;
        step("redir_lu");
        clear_inputs();
        step("redir_after");
        check("redir_flush_cnt", 32'(d_flush), 32'd1);
        check("redir_stall_cnt", 32'(d_stall), 32'd0);

        // Ack on the fourth cycle, redirect held throughout.
        do_reset();
        exmem_memread = 1'b1; ex_redirect = 1'b1;
        n_req = 0; n_wbf = 0; n_iff = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            step("memwait");
            n_req += int'(last_obs[0]);
            n_wbf += int'(last_obs[1]);
            n_iff += int'(last_obs[6]);
        end
        clear_inputs();
        step("mem_after");
        check("mem_req_cycles", 32'(n_req), 32'd4);
        check("mem_freeze_cycles", 32'(n_wbf), 32'd3);
        check("mem_ifid_flushes", 32'(n_iff), 32'd1);
        check("mem_stall_cnt", 32'(d_stall), 32'd3);
        check("mem_flush_cnt", 32'(d_flush), 32'd1);

        // Reset in the middle of a memory wait.
        do_reset();
        exmem_memwrite = 1'b1;
        step("abort0");
        step("abort1");
        reset = 1'b0;
        step("abort_rst");
        reset = 1'b1;
        clear_inputs();
        step("abort_run");

        // Timeout into ERROR, then reset back to RUN.
        do_reset();
        exmem_memwrite = 1'b1;
        for (int i = 0; i < 1 + TMO; i++) step("tmo_wait");
        step("tmo_err");
        check("tmo_err_flag", 32'(d_err), 32'd1);
        check("tmo_err_ctrl", 32'(last_obs), 32'd0);
        mem_ack = 1'b1;
        step("tmo_sticky");
        do_reset();
        step("tmo_recover");
        check("tmo_recover_err", 32'(d_err), 32'd0);
        check("tmo_recover_ctrl", 32'(last_obs), 32'h1AC);

        // Counter saturation on the 2-bit instance.
        do_reset();
        idex_memread = 1'b1; idex_rd = 5'd3; ifid_rs1 = 5'd3;
        for (int i = 0; i < 5; i++) step("sat");
        clear_inputs();
        step("sat_after");
        check("sat_stall_cnt_s", 32'(s_stall), 32'd3);
        check("sat_stall_cnt", 32'(d_stall), 32'd5);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 39) != 0);
            ifid_rs1       = 5'($urandom_range(0, 3));
            ifid_rs2       = 5'($urandom_range(0, 3));
            ifid_uses_rs2  = 1'($urandom);
            idex_memread   = 1'($urandom);
            idex_rd        = 5'($urandom_range(0, 3));
            ex_redirect    = ($urandom_range(0, 3) == 0);
            exmem_memread  = ($urandom_range(0, 3) == 0);
            exmem_memwrite = ($urandom_range(0, 5) == 0);
            mem_ack        = 1'($urandom);
            step("rand");
        end
        reset = 1'b1;
        clear_inputs();
        step("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
